// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: owns the PC, requests instructions from imem, decodes
// each returned word and hands it to the datapath with a valid/stall handshake.
module instr_fetch_issue #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_valid,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [6:0]       opcode,
    output logic [2:0]       Funct3,
    output logic [6:0]       Funct7,
    output logic [4:0]       RS1,
    output logic [4:0]       RS2,
    output logic [4:0]       RD,
    output logic [11:0]      Imm_reg,
    output logic [4:0]       Shamt,
    output logic             write_en,
    output logic             read_en,
    output logic             mem_we,
    output logic             issue_valid,
    output logic             illegal_instr
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             capture;

    logic [31:0]      instr_q;
    logic [11:0]      imm_q, dec_imm;
    logic             we_q, re_q, mwe_q, ill_q;
    logic             dec_we, dec_re, dec_mwe, dec_ill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_valid) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    state_d = FETCH;
                    // redirect targets are forced word-aligned
                    pc_d = branch_taken ? (branch_target & ~WIDTH'(3)) : (pc_q + WIDTH'(4));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dec_we  = 1'b0;
        dec_re  = 1'b0;
        dec_mwe = 1'b0;
        dec_ill = 1'b0;
        dec_imm = '0;
        case (imem_rdata[6:0])
            7'b0110011: dec_we = 1'b1;
            7'b0010011: begin
                dec_we  = 1'b1;
                dec_imm = imem_rdata[31:20];
            end
            7'b0000011: begin
                dec_we  = 1'b1;
                dec_re  = 1'b1;
                dec_imm = imem_rdata[31:20];
            end
            7'b0100011: begin
                dec_mwe = 1'b1;
                dec_imm = {imem_rdata[31:25], imem_rdata[11:7]};
            end
            7'b1100011: dec_imm = {imem_rdata[31], imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8]};
            7'b1100111: begin
                dec_we  = 1'b1;
                dec_imm = imem_rdata[31:20];
            end
            7'b1101111, 7'b0110111, 7'b0010111: dec_we = 1'b1;
            default: dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
            imm_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            mwe_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (capture) begin
            instr_q <= imem_rdata[31:0];
            imm_q   <= dec_imm;
            we_q    <= dec_we;
            re_q    <= dec_re;
            mwe_q   <= dec_mwe;
            ill_q   <= dec_ill;
        end
    end

    assign issue_valid   = (state_q == ISSUE);
    assign imem_req      = (state_q == FETCH);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;

    assign opcode        = instr_q[6:0];
    assign Funct3        = instr_q[14:12];
    assign Funct7        = instr_q[31:25];
    assign RS1           = instr_q[19:15];
    assign RS2           = instr_q[24:20];
    assign RD            = instr_q[11:7];
    assign Shamt         = instr_q[24:20];
    assign Imm_reg       = imm_q;

    // enables stay latched between issues, so gate them with the handshake
    assign write_en      = we_q  & issue_valid;
    assign read_en       = re_q  & issue_valid;
    assign mem_we        = mwe_q & issue_valid;
    assign illegal_instr = ill_q & issue_valid;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: fetch cadence, decode, stall/redirect,
// illegal opcodes, async reset mid-fetch and PC wrap.
module tb_instr_fetch_issue;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_valid, stall, branch_taken;
    logic [31:0] imem_addr, imem_rdata, branch_target, pc;
    logic [6:0]  opcode, Funct7;
    logic [2:0]  Funct3;
    logic [4:0]  RS1, RS2, RD, Shamt;
    logic [11:0] Imm_reg;
    logic        write_en, read_en, mem_we, issue_valid, illegal_instr;

    logic        rst2, imem_req2, imem_valid2, stall2, branch_taken2;
    logic [31:0] imem_addr2, imem_rdata2, branch_target2, pc2;
    logic [6:0]  opcode2, Funct72;
    logic [2:0]  Funct32;
    logic [4:0]  RS12, RS22, RD2, Shamt2;
    logic [11:0] Imm_reg2;
    logic        write_en2, read_en2, mem_we2, issue_valid2, illegal_instr2;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI  = 32'h00A00093;
    localparam logic [31:0] LOAD  = 32'h0041A103;
    localparam logic [31:0] STORE = 32'h0021A423;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] BEQ   = 32'h822004E3;
    localparam logic [31:0] JALR  = 32'h00808067;
    localparam logic [31:0] JAL   = 32'h0000006F;
    localparam logic [31:0] LUI   = 32'h12345537;

    always #5 clk = ~clk;

    instr_fetch_issue #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
        .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7), .RS1(RS1), .RS2(RS2),
        .RD(RD), .Imm_reg(Imm_reg), .Shamt(Shamt), .write_en(write_en),
        .read_en(read_en), .mem_we(mem_we), .issue_valid(issue_valid),
        .illegal_instr(illegal_instr)
    );

    instr_fetch_issue #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_valid(imem_valid2), .stall(stall2),
        .branch_taken(branch_taken2), .branch_target(branch_target2), .pc(pc2),
        .opcode(opcode2), .Funct3(Funct32), .Funct7(Funct72), .RS1(RS12), .RS2(RS22),
        .RD(RD2), .Imm_reg(Imm_reg2), .Shamt(Shamt2), .write_en(write_en2),
        .read_en(read_en2), .mem_we(mem_we2), .issue_valid(issue_valid2),
        .illegal_instr(illegal_instr2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // waits (bounded) for a fetch request, returns the word, lands in ISSUE
    task automatic deliver(input logic [31:0] ins);
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL deliver_req_timeout imem_req=%b required 1", imem_req);
        end
        imem_rdata = ins;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        checks++;
        if (issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL deliver_issue_valid got %b required 1", issue_valid);
        end
    endtask

    task automatic accept(input logic bt, input logic [31:0] tgt, input logic [31:0] exp_addr);
        stall = 1'b0;
        branch_taken = bt;
        branch_target = tgt;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (issue_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL accept_next_fetch iv=%b req=%b addr=%h required iv=0 req=1 addr=%h",
                     issue_valid, imem_req, imem_addr, exp_addr);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        rst2 = 1'b0;
        imem_valid2 = 1'b0; imem_rdata2 = '0; stall2 = 1'b0;
        branch_taken2 = 1'b0; branch_target2 = '0;
        tick(); tick(); tick();
        checks++;
        if (imem_req !== 1'b0 || issue_valid !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl req=%b iv=%b addr=%h pc=%h required 0 0 0 0",
                     imem_req, issue_valid, imem_addr, pc);
        end
        checks++;
        if ({write_en, read_en, mem_we, illegal_instr} !== 4'b0 || opcode !== 7'h0 ||
            RD !== 5'h0 || RS1 !== 5'h0 || Imm_reg !== 12'h0 || Funct7 !== 7'h0) begin
            errors++;
            $display("FAIL reset_decode en=%b op=%h rd=%h rs1=%h imm=%h f7=%h required all 0",
                     {write_en, read_en, mem_we, illegal_instr}, opcode, RD, RS1, Imm_reg, Funct7);
        end
        rst = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got %b required 0", imem_req);
        end
        tick();
    endtask

    task automatic test_fetch_cadence;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || issue_valid !== 1'b0 || imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL cadence_fetch1[%0d] req=%b iv=%b addr=%h required 1 0 %h",
                         i, imem_req, issue_valid, imem_addr, 32'(4 * i));
            end
            tick();
            checks++;
            if (imem_req !== 1'b1 || issue_valid !== 1'b0 || imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL cadence_fetch2[%0d] req=%b iv=%b addr=%h required 1 0 %h",
                         i, imem_req, issue_valid, imem_addr, 32'(4 * i));
            end
            imem_rdata = ADDI;
            imem_valid = 1'b1;
            tick();
            imem_valid = 1'b0;
            checks++;
            if (issue_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL cadence_issue[%0d] iv=%b req=%b pc=%h required 1 0 %h",
                         i, issue_valid, imem_req, pc, 32'(4 * i));
            end
            if (i == 0) begin
                checks++;
                if (opcode !== 7'b0010011 || RD !== 5'd1 || RS1 !== 5'd0 || Imm_reg !== 12'h00A ||
                    write_en !== 1'b1 || read_en !== 1'b0 || mem_we !== 1'b0 || illegal_instr !== 1'b0) begin
                    errors++;
                    $display("FAIL addi_decode op=%b rd=%0d rs1=%0d imm=%h we=%b re=%b mwe=%b ill=%b required 0010011 1 0 00a 1 0 0 0",
                             opcode, RD, RS1, Imm_reg, write_en, read_en, mem_we, illegal_instr);
                end
            end
            tick();
        end
    endtask

    task automatic test_load_store;
        deliver(LOAD);
        checks++;
        if (read_en !== 1'b1 || write_en !== 1'b1 || mem_we !== 1'b0 || Imm_reg !== 12'h004 ||
            RD !== 5'd2 || RS1 !== 5'd3 || Funct3 !== 3'd2 || opcode !== 7'b0000011 || pc !== 32'hC) begin
            errors++;
            $display("FAIL load_decode re=%b we=%b mwe=%b imm=%h rd=%0d rs1=%0d f3=%0d op=%b pc=%h",
                     read_en, write_en, mem_we, Imm_reg, RD, RS1, Funct3, opcode, pc);
        end
        accept(1'b0, 32'h0, 32'h10);
        deliver(STORE);
        checks++;
        if (mem_we !== 1'b1 || write_en !== 1'b0 || read_en !== 1'b0 || Imm_reg !== 12'h008 ||
            RS2 !== 5'd2 || RS1 !== 5'd3 || opcode !== 7'b0100011) begin
            errors++;
            $display("FAIL store_decode mwe=%b we=%b re=%b imm=%h rs2=%0d rs1=%0d op=%b",
                     mem_we, write_en, read_en, Imm_reg, RS2, RS1, opcode);
        end
        accept(1'b0, 32'h0, 32'h14);
    endtask

    task automatic test_stall_redirect;
        deliver(ADD);
        stall = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        imem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (issue_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h14 || RD !== 5'd3 ||
                RS1 !== 5'd1 || RS2 !== 5'd2 || Shamt !== 5'd2 || Imm_reg !== 12'h0 ||
                write_en !== 1'b1 || opcode !== 7'b0110011 || Funct7 !== 7'h0) begin
                errors++;
                $display("FAIL stall_hold[%0d] iv=%b req=%b pc=%h rd=%0d rs1=%0d rs2=%0d sh=%0d imm=%h we=%b op=%b",
                         i, issue_valid, imem_req, pc, RD, RS1, RS2, Shamt, Imm_reg, write_en, opcode);
            end
        end
        imem_valid = 1'b0;
        accept(1'b1, 32'h103, 32'h100);
    endtask

    task automatic test_illegal;
        branch_taken = 1'b1;
        branch_target = 32'h500;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || issue_valid !== 1'b0 || imem_addr !== 32'h100) begin
                errors++;
                $display("FAIL fetch_hold[%0d] req=%b iv=%b addr=%h required 1 0 100",
                         i, imem_req, issue_valid, imem_addr);
            end
        end
        branch_taken = 1'b0;
        deliver(ILL);
        checks++;
        if (illegal_instr !== 1'b1 || issue_valid !== 1'b1 || write_en !== 1'b0 || read_en !== 1'b0 ||
            mem_we !== 1'b0 || Imm_reg !== 12'h0 || opcode !== 7'h7F) begin
            errors++;
            $display("FAIL illegal_decode ill=%b iv=%b we=%b re=%b mwe=%b imm=%h op=%h required 1 1 0 0 0 000 7f",
                     illegal_instr, issue_valid, write_en, read_en, mem_we, Imm_reg, opcode);
        end
        accept(1'b0, 32'h0, 32'h104);
        checks++;
        if (illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after_accept got %b required 0", illegal_instr);
        end
    endtask

    task automatic test_decode_more;
        deliver(BEQ);
        checks++;
        if (Imm_reg !== 12'hC14 || write_en !== 1'b0 || read_en !== 1'b0 || mem_we !== 1'b0 ||
            illegal_instr !== 1'b0 || RS2 !== 5'd2) begin
            errors++;
            $display("FAIL branch_decode imm=%h we=%b re=%b mwe=%b ill=%b rs2=%0d required c14 0 0 0 0 2",
                     Imm_reg, write_en, read_en, mem_we, illegal_instr, RS2);
        end
        accept(1'b0, 32'h0, 32'h108);
        deliver(JALR);
        checks++;
        if (Imm_reg !== 12'h008 || write_en !== 1'b1 || RS1 !== 5'd1 || illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL jalr_decode imm=%h we=%b rs1=%0d ill=%b required 008 1 1 0",
                     Imm_reg, write_en, RS1, illegal_instr);
        end
        accept(1'b0, 32'h0, 32'h10C);
        deliver(JAL);
        checks++;
        if (Imm_reg !== 12'h0 || write_en !== 1'b1 || read_en !== 1'b0 || illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL jal_decode imm=%h we=%b re=%b ill=%b required 000 1 0 0",
                     Imm_reg, write_en, read_en, illegal_instr);
        end
        accept(1'b0, 32'h0, 32'h110);
        deliver(LUI);
        checks++;
        if (Imm_reg !== 12'h0 || write_en !== 1'b1 || RD !== 5'd10 || Funct7 !== 7'h09) begin
            errors++;
            $display("FAIL lui_decode imm=%h we=%b rd=%0d f7=%h required 000 1 10 09",
                     Imm_reg, write_en, RD, Funct7);
        end
        accept(1'b0, 32'h0, 32'h114);
    endtask

    task automatic test_async_reset;
        imem_rdata = ADDI;
        imem_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || issue_valid !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_now req=%b iv=%b addr=%h pc=%h required 0 0 0 0",
                     imem_req, issue_valid, imem_addr, pc);
        end
        #2 rst = 1'b1;
        tick();
        imem_valid = 1'b0;
        checks++;
        if (issue_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_refetch iv=%b req=%b addr=%h required 0 1 0",
                     issue_valid, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (issue_valid !== 1'b0 || write_en !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_discard iv=%b we=%b required 0 0", issue_valid, write_en);
        end
    endtask

    task automatic test_wrap;
        rst2 = 1'b1;
        tick();
        checks++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first_fetch req=%b addr=%h required 1 fffffffc", imem_req2, imem_addr2);
        end
        imem_rdata2 = ADDI;
        imem_valid2 = 1'b1;
        tick();
        imem_valid2 = 1'b0;
        checks++;
        if (issue_valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_issue iv=%b pc=%h required 1 fffffffc", issue_valid2, pc2);
        end
        tick();
        checks++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second_fetch req=%b addr=%h required 1 00000000", imem_req2, imem_addr2);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_cadence();
        test_load_store();
        test_stall_redirect();
        test_illegal();
        test_decode_more();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
